// File: rtl/gpu_pkg.sv
// Shared definitions for gpu_frame_ctrl: default word split, frame-sequencer
// state encodings and the identity-matrix element helper.
package gpu_pkg;

    localparam int GPU_M_DEF     = 11;
    localparam int GPU_N_DEF     = 7;
    localparam int GPU_MTX_ELEMS = 16;

    typedef logic [1:0] gpu_state_t;

    localparam gpu_state_t ST_IDLE  = 2'd0;
    localparam gpu_state_t ST_LOAD  = 2'd1;
    localparam gpu_state_t ST_START = 2'd2;
    localparam gpu_state_t ST_RUN   = 2'd3;

    // Diagonal elements of a row-major 4x4 matrix sit at indices 0, 5, 10, 15.
    function automatic logic [63:0] gpu_ident_elem(input int idx, input int m, input int n);
        logic [63:0] v;
        v = (idx % 5 == 0) ? (64'd1 << n) : 64'd0;
        return v & ((64'd1 << (m + n)) - 64'd1);
    endfunction

endpackage

// File: rtl/gpu_frame_ctrl_vertex_wr_port.sv
// vertex_wr_port: auto-incrementing vertex memory write port with sticky
// overflow/reject flags and registered memory-write outputs.
module vertex_wr_port
    import gpu_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int DW    = 18,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_accept_en,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_ptr_clr,
    input  logic          i_reject_clr,
    output logic [AW-1:0] o_mem_wr_addr,
    output logic [DW-1:0] o_mem_wr_data,
    output logic          o_mem_wr_en,
    output logic          o_overflow,
    output logic          o_reject
);

    // One extra bit so the pointer can rest at DEPTH once memory is full.
    logic [AW:0]   r_ptr;
    logic          r_overflow;
    logic          r_reject;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          w_full;

    assign w_full = (r_ptr == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_overflow <= 1'b0;
            r_reject   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (i_reject_clr) begin
                r_reject <= 1'b0;
            end
            // A clear coinciding with a write swallows the write silently.
            if (i_ptr_clr) begin
                r_ptr      <= '0;
                r_overflow <= 1'b0;
            end else if (i_wr_en) begin
                if (!i_accept_en) begin
                    r_reject <= 1'b1;
                end else if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_ptr[AW-1:0];
                    r_wr_data <= i_wr_data;
                    r_ptr     <= r_ptr + 1'b1;
                end
            end
        end
    end

    assign o_mem_wr_addr = r_wr_addr;
    assign o_mem_wr_data = r_wr_data;
    assign o_mem_wr_en   = r_wr_en;
    assign o_overflow    = r_overflow;
    assign o_reject      = r_reject;

endmodule

// File: rtl/gpu_frame_ctrl.sv
// gpu_frame_ctrl: host-side frame sequencer for GPU_top (shadow/active matrix,
// vertex streaming, start/frame_end sequencing). Optional watchdog: GPU_FRAME_CTRL_TIMEOUT_EN.
module gpu_frame_ctrl
    import gpu_pkg::*;
#(
    parameter int M                = GPU_M_DEF,
    parameter int N                = GPU_N_DEF,
    parameter int VERTEX_MEM_DEPTH = 16384,
    parameter int TIMEOUT_CYCLES   = 2**24,
    localparam int W               = M + N,
    localparam int AW              = $clog2(VERTEX_MEM_DEPTH)
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_go,
    input  logic                           cfg_stop,
    input  logic                           cfg_continuous,
    input  logic [31:0]                    cfg_vertex_count,
    input  logic                           mtx_wr_en,
    input  logic [3:0]                     mtx_wr_idx,
    input  logic signed [W-1:0]            mtx_wr_data,
    input  logic                           vtx_wr_en,
    input  logic [W-1:0]                   vtx_wr_data,
    input  logic                           vtx_ptr_clr,
    output logic [31:0]                    gpu_vertex_count,
    output logic                           gpu_start,
    output logic [AW-1:0]                  gpu_mem_wr_addr,
    output logic [W-1:0]                   gpu_mem_wr_data,
    output logic                           gpu_mem_wr_en,
    output logic [GPU_MTX_ELEMS*W-1:0]     gpu_transform_matrix,
    input  logic                           gpu_frame_end,
    output logic                           busy,
    output logic                           frame_done,
    output logic [15:0]                    frame_cnt,
    output logic                           vtx_overflow,
    output logic                           vtx_reject,
    output logic                           timeout
);

    gpu_state_t                 r_state;
    logic                       r_stop_pend;
    logic                       r_cont;
    logic                       r_done;
    logic [15:0]                r_frame_cnt;
    logic [31:0]                r_vcount;
    logic [GPU_MTX_ELEMS*W-1:0] r_shadow;
    logic [GPU_MTX_ELEMS*W-1:0] r_active;
    logic [GPU_MTX_ELEMS*W-1:0] w_ident;
    logic                       w_idle;
    logic                       w_go;
    logic                       w_cont_next;
    logic                       w_wd_expire;
    logic [31:0]                w_vcount_clamped;

    for (genvar g = 0; g < GPU_MTX_ELEMS; g++) begin : g_ident
        assign w_ident[g*W +: W] = W'(gpu_ident_elem(g, M, N));
    end

    assign w_idle           = (r_state == ST_IDLE);
    assign w_go             = cfg_go && w_idle;
    assign w_cont_next      = r_cont && !r_stop_pend && !cfg_stop;
    assign w_vcount_clamped = (cfg_vertex_count > 32'(VERTEX_MEM_DEPTH)) ?
                              32'(VERTEX_MEM_DEPTH) : cfg_vertex_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadow <= w_ident;
        end else if (mtx_wr_en) begin
            r_shadow[mtx_wr_idx*W +: W] <= mtx_wr_data;
        end
    end

`ifdef GPU_FRAME_CTRL_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_timeout;

    assign w_wd_expire = (r_state == ST_RUN) && !gpu_frame_end &&
                         (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign timeout     = r_timeout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_go) begin
                r_timeout <= 1'b0;
            end else if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
            r_wd_cnt <= (r_state == ST_RUN) ? r_wd_cnt + 32'd1 : 32'd0;
        end
    end
`else
    assign w_wd_expire = 1'b0;
    // Evaluates to 0 for every legal limit; without the watchdog nothing times out.
    assign timeout     = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_stop_pend <= 1'b0;
            r_cont      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
            r_vcount    <= '0;
            r_active    <= w_ident;
        end else begin
            r_done <= 1'b0;
            if (cfg_stop && !w_idle) begin
                r_stop_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cfg_go) begin
                        r_state <= ST_LOAD;
                        r_cont  <= cfg_continuous;
                    end
                end
                ST_LOAD: begin
                    r_active <= r_shadow;
                    r_vcount <= w_vcount_clamped;
                    // An empty frame completes immediately without touching the GPU.
                    if (w_vcount_clamped == 32'd0) begin
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        if (!w_cont_next) begin
                            r_state     <= ST_IDLE;
                            r_stop_pend <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (gpu_frame_end) begin
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        if (w_cont_next) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_stop_pend <= 1'b0;
                        end
                    end else if (w_wd_expire) begin
                        r_state     <= ST_IDLE;
                        r_stop_pend <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    vertex_wr_port #(
        .DEPTH (VERTEX_MEM_DEPTH),
        .DW    (W)
    ) u_vertex_wr_port (
        .clk           (clk),
        .reset         (reset),
        .i_accept_en   (w_idle),
        .i_wr_en       (vtx_wr_en),
        .i_wr_data     (vtx_wr_data),
        .i_ptr_clr     (vtx_ptr_clr),
        .i_reject_clr  (w_go),
        .o_mem_wr_addr (gpu_mem_wr_addr),
        .o_mem_wr_data (gpu_mem_wr_data),
        .o_mem_wr_en   (gpu_mem_wr_en),
        .o_overflow    (vtx_overflow),
        .o_reject      (vtx_reject)
    );

    assign gpu_start            = (r_state == ST_START);
    assign busy                 = !w_idle;
    assign frame_done           = r_done;
    assign frame_cnt            = r_frame_cnt;
    assign gpu_vertex_count     = r_vcount;
    assign gpu_transform_matrix = r_active;

endmodule

// File: tb/tb_gpu_frame_ctrl.sv
// Self-checking bench for gpu_frame_ctrl: a cycle-timeline model filled by the
// stimulus tasks, compared against the DUT every cycle, plus literal spot checks.
module tb_gpu_frame_ctrl;

    localparam int M     = 11;
    localparam int N     = 7;
    localparam int W     = M + N;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int TMO   = 16;
    localparam int MAXC  = 1024;
    localparam int ONE   = 1 << N;

    localparam int L_BUSY = 0, L_CNT = 1, L_OVF = 2, L_REJ = 3;
    localparam int L_TMO  = 4, L_VC  = 5, L_M0  = 6, L_M5  = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cfg_go = 1'b0;
    logic              cfg_stop = 1'b0;
    logic              cfg_continuous = 1'b0;
    logic [31:0]       cfg_vertex_count = '0;
    logic              mtx_wr_en = 1'b0;
    logic [3:0]        mtx_wr_idx = '0;
    logic [W-1:0]      mtx_wr_data = '0;
    logic              vtx_wr_en = 1'b0;
    logic [W-1:0]      vtx_wr_data = '0;
    logic              vtx_ptr_clr = 1'b0;
    logic              gpu_frame_end = 1'b0;
    logic [31:0]       gpu_vertex_count;
    logic              gpu_start;
    logic [AW-1:0]     gpu_mem_wr_addr;
    logic [W-1:0]      gpu_mem_wr_data;
    logic              gpu_mem_wr_en;
    logic [16*W-1:0]   gpu_transform_matrix;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_cnt;
    logic              vtx_overflow;
    logic              vtx_reject;
    logic              timeout;

    always #5 clk = ~clk;

    gpu_frame_ctrl #(
        .M(M), .N(N), .VERTEX_MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .cfg_go(cfg_go), .cfg_stop(cfg_stop),
        .cfg_continuous(cfg_continuous), .cfg_vertex_count(cfg_vertex_count),
        .mtx_wr_en(mtx_wr_en), .mtx_wr_idx(mtx_wr_idx), .mtx_wr_data(mtx_wr_data),
        .vtx_wr_en(vtx_wr_en), .vtx_wr_data(vtx_wr_data), .vtx_ptr_clr(vtx_ptr_clr),
        .gpu_vertex_count(gpu_vertex_count), .gpu_start(gpu_start),
        .gpu_mem_wr_addr(gpu_mem_wr_addr), .gpu_mem_wr_data(gpu_mem_wr_data),
        .gpu_mem_wr_en(gpu_mem_wr_en), .gpu_transform_matrix(gpu_transform_matrix),
        .gpu_frame_end(gpu_frame_end), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .vtx_overflow(vtx_overflow), .vtx_reject(vtx_reject),
        .timeout(timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    // Expected timeline: one-cycle pulses and level values per cycle.
    bit e_start [MAXC];
    bit e_done  [MAXC];
    bit e_wr    [MAXC];
    int e_wa    [MAXC];
    int e_wd    [MAXC];
    int lv      [8][MAXC];

    // Abstract model state.
    int m_ptr = 0;
    int m_cnt = 0;
    int m_vc  = 0;
    bit m_busy = 1'b0;
    int m_shadow [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_lv(input int which, input int from, input int v);
        for (int i = from; i < MAXC; i++) lv[which][i] = v;
    endtask

    function automatic int elem(input int idx);
        return int'(gpu_transform_matrix[idx*W +: W]);
    endfunction

    always @(negedge clk) begin
        if (cmp_on && cyc >= 1 && cyc < MAXC) begin
            chk("gpu_start",    gpu_start,     e_start[cyc]);
            chk("frame_done",   frame_done,    e_done[cyc]);
            chk("mem_wr_en",    gpu_mem_wr_en, e_wr[cyc]);
            if (e_wr[cyc]) begin
                chk("mem_wr_addr", gpu_mem_wr_addr, e_wa[cyc]);
                chk("mem_wr_data", gpu_mem_wr_data, e_wd[cyc]);
            end
            chk("busy",         busy,             lv[L_BUSY][cyc]);
            chk("frame_cnt",    frame_cnt,        lv[L_CNT][cyc]);
            chk("vtx_overflow", vtx_overflow,     lv[L_OVF][cyc]);
            chk("vtx_reject",   vtx_reject,       lv[L_REJ][cyc]);
            chk("timeout",      timeout,          lv[L_TMO][cyc]);
            chk("vertex_count", gpu_vertex_count, lv[L_VC][cyc]);
            chk("mtx_elem0",    elem(0),          lv[L_M0][cyc]);
            chk("mtx_elem5",    elem(5),          lv[L_M5][cyc]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_model(input int from);
        m_ptr = 0; m_cnt = 0; m_vc = 0; m_busy = 1'b0;
        for (int i = 0; i < 16; i++) m_shadow[i] = (i % 5 == 0) ? ONE : 0;
        set_lv(L_BUSY, from, 0); set_lv(L_CNT, from, 0); set_lv(L_OVF, from, 0);
        set_lv(L_REJ, from, 0);  set_lv(L_TMO, from, 0); set_lv(L_VC, from, 0);
        set_lv(L_M0, from, ONE); set_lv(L_M5, from, ONE);
    endtask

    // LOAD in cycle tl: active matrix and clamped count become visible at tl+1.
    task automatic load_model(input int tl, input int count);
        m_vc = (count > DEPTH) ? DEPTH : count;
        set_lv(L_M0, tl + 1, m_shadow[0]);
        set_lv(L_M5, tl + 1, m_shadow[5]);
        set_lv(L_VC, tl + 1, m_vc);
    endtask

    task automatic vtx_write(input int d);
        vtx_wr_en = 1'b1; vtx_wr_data = W'(d);
        if (m_busy) set_lv(L_REJ, cyc + 1, 1);
        else if (m_ptr == DEPTH) set_lv(L_OVF, cyc + 1, 1);
        else begin
            e_wr[cyc + 1] = 1'b1; e_wa[cyc + 1] = m_ptr; e_wd[cyc + 1] = d;
            m_ptr++;
        end
        step(1);
        vtx_wr_en = 1'b0;
    endtask

    task automatic ptr_clear(input bit with_wr, input int d);
        vtx_ptr_clr = 1'b1;
        vtx_wr_en = with_wr; vtx_wr_data = W'(d);
        m_ptr = 0;
        set_lv(L_OVF, cyc + 1, 0);
        step(1);
        vtx_ptr_clr = 1'b0; vtx_wr_en = 1'b0;
    endtask

    task automatic mtx_write(input int idx, input int v);
        mtx_wr_en = 1'b1; mtx_wr_idx = 4'(idx); mtx_wr_data = W'(v);
        m_shadow[idx] = v;
        step(1);
        mtx_wr_en = 1'b0;
    endtask

    task automatic go(input int count, input bit cont);
        int t;
        t = cyc;
        cfg_go = 1'b1; cfg_continuous = cont; cfg_vertex_count = 32'(count);
        set_lv(L_BUSY, t + 1, 1); set_lv(L_REJ, t + 1, 0); set_lv(L_TMO, t + 1, 0);
        load_model(t + 1, count);
        if (m_vc == 0) begin
            e_done[t + 2] = 1'b1; m_cnt++;
            set_lv(L_CNT, t + 2, m_cnt & 16'hFFFF);
            set_lv(L_BUSY, t + 2, 0);
        end else begin
            e_start[t + 2] = 1'b1;
        end
        step(1);
        cfg_go = 1'b0; cfg_continuous = 1'b0;
        m_busy = 1'b1;
        if (m_vc == 0) begin
            step(1);
            m_busy = 1'b0;
        end
    endtask

    task automatic go_ignored();
        cfg_go = 1'b1;
        step(1);
        cfg_go = 1'b0;
    endtask

    task automatic frame_end(input bit cont_next);
        int e;
        e = cyc;
        gpu_frame_end = 1'b1;
        e_done[e + 1] = 1'b1; m_cnt++;
        set_lv(L_CNT, e + 1, m_cnt & 16'hFFFF);
        if (cont_next) begin
            load_model(e + 1, int'(cfg_vertex_count));
            e_start[e + 2] = 1'b1;
        end else begin
            set_lv(L_BUSY, e + 1, 0);
        end
        step(1);
        gpu_frame_end = 1'b0;
        if (!cont_next) m_busy = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        step(1);
        cfg_stop = 1'b0;
    endtask

    initial begin
        int t0;
        for (int i = 0; i < MAXC; i++) begin
            e_start[i] = 1'b0; e_done[i] = 1'b0; e_wr[i] = 1'b0; e_wa[i] = 0; e_wd[i] = 0;
        end
        reset_model(0);
        cmp_on = 1'b1;

        // Reset state
        step(3);
        reset = 1'b1;
        chk("lit_reset_elem10", elem(10), 18'h80);
        chk("lit_reset_elem15", elem(15), 18'h80);
        chk("lit_reset_elem1",  elem(1),  18'h0);
        chk("lit_reset_cnt",    frame_cnt, 16'd0);

        // Three vertex writes stream to addresses 0, 1, 2
        vtx_write(11); vtx_write(22); vtx_write(33);
        chk("lit_vtx3_addr", gpu_mem_wr_addr, 2'd2);
        chk("lit_vtx3_data", gpu_mem_wr_data, 18'd33);

        // Single-shot frame; matrix write during LOAD is excluded
        mtx_write(5, 'h100);
        go(3, 1'b0);
        mtx_write(0, 'h55);
        chk("lit_start_pulse", gpu_start, 1'b1);
        chk("lit_elem5_new",   elem(5), 18'h100);
        chk("lit_elem0_old",   elem(0), 18'h80);
        vtx_write(44);
        go_ignored();
        step(2);
        frame_end(1'b0);
        chk("lit_done",     frame_done, 1'b1);
        chk("lit_cnt1",     frame_cnt, 16'd1);
        chk("lit_busy_low", busy, 1'b0);
        step(1);
        gpu_frame_end = 1'b1; step(1); gpu_frame_end = 1'b0;

        // Continuous mode, stop during the second RUN
        go(2, 1'b1);
        step(2);
        mtx_write(5, 'h200);
        frame_end(1'b1);
        step(2);
        pulse_stop();
        step(1);
        frame_end(1'b0);
        chk("lit_cnt3", frame_cnt, 16'd3);

        // Pointer saturation, clear, clear-wins-over-write
        ptr_clear(1'b0, 0);
        vtx_write(1); vtx_write(2); vtx_write(3); vtx_write(4); vtx_write(5);
        chk("lit_overflow", vtx_overflow, 1'b1);
        ptr_clear(1'b0, 0);
        ptr_clear(1'b1, 99);
        vtx_write(77);
        chk("lit_after_clr_addr", gpu_mem_wr_addr, 2'd0);
        chk("lit_after_clr_data", gpu_mem_wr_data, 18'd77);

        // Empty frame, then a clamped frame with a rejected write
        go(0, 1'b0);
        chk("lit_zero_done",  frame_done, 1'b1);
        chk("lit_zero_start", gpu_start, 1'b0);
        t0 = cyc;
        go(9, 1'b0);
        step(2);
        vtx_write(5);
`ifdef GPU_FRAME_CTRL_TIMEOUT_EN
        set_lv(L_TMO, t0 + 3 + TMO, 1);
        set_lv(L_BUSY, t0 + 3 + TMO, 0);
        for (int k = 0; k < 100 && cyc < t0 + 3 + TMO; k++) step(1);
        m_busy = 1'b0;
        chk("lit_timeout",     timeout, 1'b1);
        chk("lit_timeout_cnt", frame_cnt, 16'd4);
`else
        step(30);
        chk("lit_still_busy", busy, 1'b1);
        frame_end(1'b0);
`endif
        go(1, 1'b0);
        step(2);
        frame_end(1'b0);

        // Reset in the middle of a frame
        go(2, 1'b0);
        step(2);
        reset = 1'b0;
        reset_model(cyc + 1);
        step(1);
        reset = 1'b1;
        chk("lit_midreset_cnt",  frame_cnt, 16'd0);
        chk("lit_midreset_busy", busy, 1'b0);
        vtx_write(3);
        go(0, 1'b0);
        step(3);

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
